// File: rtl/console_pkg.sv
`default_nettype none
// ============================================================================
// Module      : console_pkg
// Description : Shared types and constants for the console traffic controller:
//               TX arbiter state encoding, grant identifiers, ASCII codes.
// Revision    : 1.0 - initial release
// ============================================================================
package console_pkg;

    // TX arbiter states
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GNT_CPU = 2'd1,
        GNT_DBG = 2'd2
    } arb_state_t;

    // Identity of the requester that was granted most recently
    localparam logic GRANT_CPU = 1'b0;
    localparam logic GRANT_DBG = 1'b1;

    // ASCII line-ending bytes used by debug sources and benches
    localparam logic [7:0] CR = 8'h0D;
    localparam logic [7:0] LF = 8'h0A;

endpackage
`default_nettype wire

// File: rtl/console_rx_fifo.sv
`default_nettype none
// ============================================================================
// Module      : console_rx_fifo
// Description : Receive-byte FIFO. Pointers carry one extra wrap bit so full
//               and empty are distinguishable without a separate counter.
//               A push into a full FIFO is accepted when a pop happens in
//               the same cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module console_rx_fifo
    import console_pkg::*;
#(
    parameter int FIFO_DEPTH = 16,
    parameter int FIFO_AW    = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [7:0]         i_push_data,
    input  logic               i_push_valid,
    input  logic               i_pop,
    output logic [7:0]         o_head,
    output logic [FIFO_AW:0]   o_count,
    output logic               o_full,
    output logic               o_empty
);

    logic [7:0]       r_mem [FIFO_DEPTH];
    logic [FIFO_AW:0] r_wr_ptr;
    logic [FIFO_AW:0] r_rd_ptr;
    logic             w_pop;
    logic             w_push;

    assign o_empty = (r_wr_ptr == r_rd_ptr);
    assign o_full  = (r_wr_ptr[FIFO_AW] != r_rd_ptr[FIFO_AW]) &&
                     (r_wr_ptr[FIFO_AW-1:0] == r_rd_ptr[FIFO_AW-1:0]);

    // A pop frees the slot the push lands in, so full only blocks a lone push
    assign w_pop   = i_pop & ~o_empty;
    assign w_push  = i_push_valid & (~o_full | w_pop);

    assign o_count = r_wr_ptr - r_rd_ptr;

    // Head byte reads as zero while empty so the output is clean after reset
    assign o_head  = o_empty ? 8'h00 : r_mem[r_rd_ptr[FIFO_AW-1:0]];

    // Pointer advance on accepted push and pop
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    // Storage write; contents need no reset because empty masks the head
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr[FIFO_AW-1:0]] <= i_push_data;
    end

endmodule
`default_nettype wire

// File: rtl/console_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : console_ctrl
// Description : Console traffic controller between the board UART and the
//               processor wrapper. RX bytes are buffered and handed out one
//               per rising edge of the processor ack; the single UART
//               transmitter is shared between the processor and a debug
//               message source, with debug messages never interleaved.
// Revision    : 1.0 - initial release
// ============================================================================
module console_ctrl
    import console_pkg::*;
#(
    parameter int FIFO_DEPTH = 16,
    parameter int FIFO_AW    = 4
) (
    input  logic               CLK,
    input  logic               RESET,
    input  logic [7:0]         RX_DATA,
    input  logic               RX_VALID,
    input  logic               OVR_CLR,
    output logic               RX_OVERRUN,
    output logic [FIFO_AW:0]   RX_COUNT,
    output logic [7:0]         CONSOLE_IN,
    output logic               CONSOLE_IN_valid,
    input  logic               CONSOLE_IN_ack,
    input  logic [7:0]         CONSOLE_OUT,
    input  logic               CONSOLE_OUT_valid,
    output logic               CONSOLE_OUT_ready,
    input  logic [7:0]         DBG_DATA,
    input  logic               DBG_VALID,
    input  logic               DBG_LAST,
    output logic               DBG_READY,
    output logic [7:0]         TX_DATA,
    output logic               TX_VALID,
    input  logic               TX_READY
);

    logic       r_ack_q;
    logic       r_overrun;
    logic       w_pop;
    logic       w_full;
    logic       w_empty;
    logic       w_ovr_evt;
    arb_state_t r_state;
    logic       r_last_grant;

    // ------------------------------------------------------------------
    // RX path
    // ------------------------------------------------------------------
    assign CONSOLE_IN_valid = ~w_empty;

    // One pop per ack pulse, however long the processor holds ack high
    assign w_pop = ~w_empty & CONSOLE_IN_ack & ~r_ack_q;

    // A byte is lost only when full and nothing leaves in the same cycle
    assign w_ovr_evt = RX_VALID & w_full & ~w_pop;

    assign RX_OVERRUN = r_overrun;

    console_rx_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH),
        .FIFO_AW    (FIFO_AW)
    ) u_rx_fifo (
        .clk          (CLK),
        .rst          (RESET),
        .i_push_data  (RX_DATA),
        .i_push_valid (RX_VALID),
        .i_pop        (w_pop),
        .o_head       (CONSOLE_IN),
        .o_count      (RX_COUNT),
        .o_full       (w_full),
        .o_empty      (w_empty)
    );

    // Ack edge history and sticky overrun flag; a new overrun beats a clear
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_ack_q   <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            r_ack_q <= CONSOLE_IN_ack;
            if (w_ovr_evt)
                r_overrun <= 1'b1;
            else if (OVR_CLR)
                r_overrun <= 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // TX arbiter
    // ------------------------------------------------------------------

    // Grant state machine; on a tie the requester not served last wins
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_state      <= IDLE;
            r_last_grant <= GRANT_DBG;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (CONSOLE_OUT_valid && DBG_VALID)
                        r_state <= (r_last_grant == GRANT_DBG) ? GNT_CPU : GNT_DBG;
                    else if (CONSOLE_OUT_valid)
                        r_state <= GNT_CPU;
                    else if (DBG_VALID)
                        r_state <= GNT_DBG;
                end
                GNT_CPU: begin
                    if (CONSOLE_OUT_valid && TX_READY) begin
                        r_state      <= IDLE;
                        r_last_grant <= GRANT_CPU;
                    end else if (!CONSOLE_OUT_valid) begin
                        r_state <= IDLE;
                    end
                end
                GNT_DBG: begin
                    // Grant is held through gaps until the final byte moves
                    if (DBG_VALID && TX_READY && DBG_LAST) begin
                        r_state      <= IDLE;
                        r_last_grant <= GRANT_DBG;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Route the granted requester to the transmitter; the other sees no ready
    always_comb begin
        TX_DATA           = 8'h00;
        TX_VALID          = 1'b0;
        CONSOLE_OUT_ready = 1'b0;
        DBG_READY         = 1'b0;
        unique case (r_state)
            GNT_CPU: begin
                TX_DATA           = CONSOLE_OUT;
                TX_VALID          = CONSOLE_OUT_valid;
                CONSOLE_OUT_ready = TX_READY;
            end
            GNT_DBG: begin
                TX_DATA   = DBG_DATA;
                TX_VALID  = DBG_VALID;
                DBG_READY = TX_READY;
            end
            default: ;
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_console_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_console_ctrl
// Description : Self-checking bench for console_ctrl. Drivers push expected
//               bytes into scoreboard queues; a negedge monitor keeps a
//               queue-level model of the RX buffer and compares every
//               transfer the DUT presents.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_console_ctrl;
    import console_pkg::*;

    localparam int DEPTH = 16;

    logic       CLK = 1'b0;
    logic       RESET;
    logic [7:0] RX_DATA;
    logic       RX_VALID;
    logic       OVR_CLR;
    logic       RX_OVERRUN;
    logic [4:0] RX_COUNT;
    logic [7:0] CONSOLE_IN;
    logic       CONSOLE_IN_valid;
    logic       CONSOLE_IN_ack;
    logic [7:0] CONSOLE_OUT;
    logic       CONSOLE_OUT_valid;
    logic       CONSOLE_OUT_ready;
    logic [7:0] DBG_DATA;
    logic       DBG_VALID;
    logic       DBG_LAST;
    logic       DBG_READY;
    logic [7:0] TX_DATA;
    logic       TX_VALID;
    logic       TX_READY;

    always #5 CLK = ~CLK;

    console_ctrl #(.FIFO_DEPTH(16), .FIFO_AW(4)) dut (
        .CLK               (CLK),
        .RESET             (RESET),
        .RX_DATA           (RX_DATA),
        .RX_VALID          (RX_VALID),
        .OVR_CLR           (OVR_CLR),
        .RX_OVERRUN        (RX_OVERRUN),
        .RX_COUNT          (RX_COUNT),
        .CONSOLE_IN        (CONSOLE_IN),
        .CONSOLE_IN_valid  (CONSOLE_IN_valid),
        .CONSOLE_IN_ack    (CONSOLE_IN_ack),
        .CONSOLE_OUT       (CONSOLE_OUT),
        .CONSOLE_OUT_valid (CONSOLE_OUT_valid),
        .CONSOLE_OUT_ready (CONSOLE_OUT_ready),
        .DBG_DATA          (DBG_DATA),
        .DBG_VALID         (DBG_VALID),
        .DBG_LAST          (DBG_LAST),
        .DBG_READY         (DBG_READY),
        .TX_DATA           (TX_DATA),
        .TX_VALID          (TX_VALID),
        .TX_READY          (TX_READY)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Scoreboards and model state
    logic [7:0] rx_exp[$];
    logic [7:0] cpu_exp[$];
    logic [8:0] dbg_exp[$];   // {last, data}
    bit         xfer_log[$];  // 0 = CPU transfer, 1 = DBG transfer
    logic       m_ovr      = 1'b0;
    logic       ack_prev   = 1'b0;
    logic       hold       = 1'b0;
    logic [7:0] hold_data  = 8'h00;
    logic       dbg_in_msg = 1'b0;
    logic       tx_done    = 1'b0;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic void fail(input string name);
        n_checks++;
        n_errors++;
        $display("FAIL %s at %0t", name, $time);
    endfunction

    // Monitor: compare DUT against the queue model, then advance the model
    always @(negedge CLK) begin
        if (RESET) begin
            chk("rst_count",   32'(RX_COUNT), 0);
            chk("rst_invalid", 32'(CONSOLE_IN_valid), 0);
            chk("rst_indata",  32'(CONSOLE_IN), 0);
            chk("rst_ovr",     32'(RX_OVERRUN), 0);
            chk("rst_txvalid", 32'(TX_VALID), 0);
            chk("rst_txdata",  32'(TX_DATA), 0);
            chk("rst_cpurdy",  32'(CONSOLE_OUT_ready), 0);
            chk("rst_dbgrdy",  32'(DBG_READY), 0);
            rx_exp.delete();
            cpu_exp.delete();
            dbg_exp.delete();
            xfer_log.delete();
            m_ovr      = 1'b0;
            ack_prev   = 1'b0;
            hold       = 1'b0;
            dbg_in_msg = 1'b0;
        end else begin
            int  sz;
            bit  pop;
            bit  ovr_evt;
            sz = rx_exp.size();
            chk("rx_count", 32'(RX_COUNT), sz);
            chk("in_valid", 32'(CONSOLE_IN_valid), (sz != 0) ? 1 : 0);
            if (sz != 0) chk("in_data", 32'(CONSOLE_IN), 32'(rx_exp[0]));
            chk("overrun", 32'(RX_OVERRUN), 32'(m_ovr));
            pop     = (sz != 0) && CONSOLE_IN_ack && !ack_prev;
            ovr_evt = RX_VALID && (sz == DEPTH) && !pop;
            if (pop) void'(rx_exp.pop_front());
            if (RX_VALID && !ovr_evt) rx_exp.push_back(RX_DATA);
            if (ovr_evt)      m_ovr = 1'b1;
            else if (OVR_CLR) m_ovr = 1'b0;
            ack_prev = CONSOLE_IN_ack;

            chk("ready_excl", 32'(CONSOLE_OUT_ready & DBG_READY), 0);
            if (hold) begin
                chk("tx_hold_valid", 32'(TX_VALID), 1);
                chk("tx_hold_data",  32'(TX_DATA), 32'(hold_data));
            end
            if (CONSOLE_OUT_valid && CONSOLE_OUT_ready) begin
                chk("cpu_txvalid", 32'(TX_VALID), 1);
                chk("no_interleave", 32'(dbg_in_msg), 0);
                if (cpu_exp.size() == 0) fail("cpu_unexpected_xfer");
                else chk("cpu_data", 32'(TX_DATA), 32'(cpu_exp.pop_front()));
                xfer_log.push_back(1'b0);
            end
            if (DBG_VALID && DBG_READY) begin
                chk("dbg_txvalid", 32'(TX_VALID), 1);
                if (dbg_exp.size() == 0) fail("dbg_unexpected_xfer");
                else begin
                    logic [8:0] e;
                    e = dbg_exp.pop_front();
                    chk("dbg_data", 32'(TX_DATA), 32'(e[7:0]));
                    dbg_in_msg = ~e[8];
                end
                xfer_log.push_back(1'b1);
            end
            hold      = TX_VALID && !TX_READY;
            hold_data = TX_DATA;
        end
    end

    task automatic rx_strobe(input logic [7:0] b);
        RX_DATA  = b;
        RX_VALID = 1'b1;
        @(posedge CLK); #1;
        RX_VALID = 1'b0;
    endtask

    task automatic ack_pulse(input int len);
        CONSOLE_IN_ack = 1'b1;
        repeat (len) @(posedge CLK);
        #1 CONSOLE_IN_ack = 1'b0;
        @(posedge CLK); #1;
    endtask

    task automatic cpu_send(input logic [7:0] b);
        bit done;
        done = 0;
        CONSOLE_OUT       = b;
        CONSOLE_OUT_valid = 1'b1;
        cpu_exp.push_back(b);
        for (int i = 0; i < 3000 && !done; i++) begin
            @(negedge CLK);
            if (CONSOLE_OUT_ready) done = 1;
        end
        if (!done) fail("cpu_send_timeout");
        @(posedge CLK); #1;
        CONSOLE_OUT_valid = 1'b0;
    endtask

    task automatic dbg_msg(input int n, input int maxgap);
        for (int k = 0; k < n; k++) begin
            bit         done;
            logic [7:0] b;
            int         gap;
            done      = 0;
            b         = 8'($urandom);
            DBG_DATA  = b;
            DBG_LAST  = (k == n - 1);
            DBG_VALID = 1'b1;
            dbg_exp.push_back({DBG_LAST, b});
            for (int i = 0; i < 3000 && !done; i++) begin
                @(negedge CLK);
                if (DBG_READY) done = 1;
            end
            if (!done) fail("dbg_send_timeout");
            @(posedge CLK); #1;
            DBG_VALID = 1'b0;
            DBG_LAST  = 1'b0;
            gap = $urandom_range(0, maxgap);
            repeat (gap) begin @(posedge CLK); #1; end
        end
    endtask

    task automatic do_reset();
        RESET             = 1'b1;
        RX_VALID          = 1'b0;
        CONSOLE_IN_ack    = 1'b0;
        OVR_CLR           = 1'b0;
        CONSOLE_OUT_valid = 1'b0;
        DBG_VALID         = 1'b0;
        DBG_LAST          = 1'b0;
        repeat (2) @(posedge CLK);
        #1 RESET = 1'b0;
    endtask

    initial begin
        logic [7:0] t1_bytes [3];
        bit         t4_order [5];
        t1_bytes = '{8'h50, 8'h41, CR};
        t4_order = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        RX_DATA = 8'h00; CONSOLE_OUT = 8'h00; DBG_DATA = 8'h00; TX_READY = 1'b1;
        do_reset();

        // RX bytes handed out one per ack pulse
        rx_strobe(8'h50); rx_strobe(8'h41); rx_strobe(CR);
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK) chk("t1_head", 32'(CONSOLE_IN), 32'(t1_bytes[i]));
            ack_pulse(3);
        end
        @(negedge CLK);
        chk("t1_count", 32'(RX_COUNT), 0);
        chk("t1_valid", 32'(CONSOLE_IN_valid), 0);

        // Overfill, overrun flag, ordered readout, flag clear
        for (int i = 1; i <= 17; i++) rx_strobe(8'(i));
        @(negedge CLK);
        chk("t2_count", 32'(RX_COUNT), 16);
        chk("t2_ovr",   32'(RX_OVERRUN), 1);
        for (int i = 1; i <= 16; i++) begin
            @(negedge CLK) chk("t2_head", 32'(CONSOLE_IN), i);
            ack_pulse(1);
        end
        OVR_CLR = 1'b1;
        @(posedge CLK); #1 OVR_CLR = 1'b0;
        @(negedge CLK) chk("t2_ovr_clr", 32'(RX_OVERRUN), 0);

        // Push into full FIFO with a coincident pop
        for (int i = 0; i < 16; i++) rx_strobe(8'(8'h60 + i));
        RX_DATA = 8'hAB; RX_VALID = 1'b1; CONSOLE_IN_ack = 1'b1;
        @(posedge CLK); #1 RX_VALID = 1'b0; CONSOLE_IN_ack = 1'b0;
        @(negedge CLK);
        chk("t3_count", 32'(RX_COUNT), 16);
        chk("t3_ovr",   32'(RX_OVERRUN), 0);
        for (int i = 0; i < 16; i++) begin
            @(negedge CLK) chk("t3_head", 32'(CONSOLE_IN), (i == 15) ? 32'hAB : 32'(8'h61 + i));
            ack_pulse(1);
        end

        // Simultaneous CPU/DBG from reset; CPU request during a message waits
        do_reset();
        TX_READY = 1'b1;
        fork
            cpu_send(8'h11);
            dbg_msg(3, 0);
            begin
                for (int i = 0; i < 500 && xfer_log.size() < 2; i++) @(negedge CLK);
                @(posedge CLK); #1;
                cpu_send(8'h22);
            end
        join
        chk("t4_nxfer", xfer_log.size(), 5);
        if (xfer_log.size() == 5)
            for (int i = 0; i < 5; i++) chk("t4_order", 32'(xfer_log[i]), 32'(t4_order[i]));

        // Back-pressure while CPU is granted
        TX_READY = 1'b0;
        fork
            cpu_send(8'h57);
        join_none
        @(posedge CLK);
        for (int i = 0; i < 10; i++) begin
            @(negedge CLK);
            chk("t5_valid", 32'(TX_VALID), 1);
            chk("t5_data",  32'(TX_DATA), 32'h57);
            chk("t5_ready", 32'(CONSOLE_OUT_ready), 0);
        end
        @(posedge CLK); #1 TX_READY = 1'b1;
        wait fork;

        // Asynchronous reset mid-message with RX bytes buffered
        for (int i = 0; i < 5; i++) rx_strobe(8'($urandom));
        @(negedge CLK) chk("t6_count5", 32'(RX_COUNT), 5);
        DBG_DATA = 8'hC1; DBG_LAST = 1'b0; DBG_VALID = 1'b1;
        dbg_exp.push_back({1'b0, 8'hC1});
        begin
            bit done;
            done = 0;
            for (int i = 0; i < 100 && !done; i++) begin
                @(negedge CLK);
                if (DBG_READY) done = 1;
            end
            if (!done) fail("t6_dbg_timeout");
        end
        @(posedge CLK); #1;
        DBG_DATA = 8'hC2; TX_READY = 1'b0;
        dbg_exp.push_back({1'b0, 8'hC2});
        @(negedge CLK) chk("t6_pending", 32'(TX_VALID), 1);
        #2 RESET = 1'b1;
        #1;
        chk("t6_txvalid", 32'(TX_VALID), 0);
        chk("t6_txdata",  32'(TX_DATA), 0);
        chk("t6_dbgrdy",  32'(DBG_READY), 0);
        chk("t6_count",   32'(RX_COUNT), 0);
        chk("t6_invalid", 32'(CONSOLE_IN_valid), 0);
        DBG_VALID = 1'b0; TX_READY = 1'b1;
        repeat (2) @(posedge CLK);
        #1 RESET = 1'b0;
        fork
            cpu_send(8'h33);
            dbg_msg(1, 0);
        join
        chk("t6_nxfer", xfer_log.size(), 2);
        if (xfer_log.size() > 0) chk("t6_cpu_first", 32'(xfer_log[0]), 0);

        // Randomised traffic on both paths
        fork
            begin
                fork
                    for (int i = 0; i < 25; i++) begin
                        int gap;
                        cpu_send(8'($urandom));
                        gap = $urandom_range(0, 4);
                        repeat (gap) begin @(posedge CLK); #1; end
                    end
                    for (int i = 0; i < 8; i++) begin
                        int gap;
                        dbg_msg($urandom_range(1, 4), 3);
                        gap = $urandom_range(0, 4);
                        repeat (gap) begin @(posedge CLK); #1; end
                    end
                join
                tx_done = 1'b1;
            end
            begin
                while (!tx_done) begin
                    TX_READY = ($urandom_range(0, 9) < 7);
                    @(posedge CLK); #1;
                end
                TX_READY = 1'b1;
            end
            begin
                for (int c = 0; c < 600; c++) begin
                    RX_VALID       = ($urandom_range(0, 2) == 0);
                    RX_DATA        = 8'($urandom);
                    CONSOLE_IN_ack = ($urandom_range(0, 99) < ((c < 300) ? 15 : 60));
                    OVR_CLR        = ($urandom_range(0, 40) == 0);
                    @(posedge CLK); #1;
                end
                RX_VALID = 1'b0; CONSOLE_IN_ack = 1'b0; OVR_CLR = 1'b0;
            end
        join

        // Drain what is left in the RX buffer
        for (int i = 0; i < 40 && RX_COUNT != 0; i++) ack_pulse(1);
        @(negedge CLK);
        chk("end_rx_empty", rx_exp.size(), 0);
        chk("end_cpu_done", cpu_exp.size(), 0);
        chk("end_dbg_done", dbg_exp.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    // Watchdog so the run always ends
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
